shift_rotate_engine: RTL
========================

// Module: shift_rotate_engine
// PURPOSE
//  Parametrised successor to the fixed 8-bit rotate register: WIDTH-bit register
//  with parallel load, four shift/rotate modes and a counted multi-step command.
//  start/busy/done handshake; one step per clock.
//  Used as pattern generator / LED chaser / serialiser in lab datapaths.
// PARAMETERS
//  WIDTH      8             register width, >= 2
//  RESET_VAL  8'b10010110   q value after reset (WIDTH bits)
//  MAX_STEPS  WIDTH         largest step count honoured; larger requests clamp
//  CNT_W      $clog2(MAX_STEPS+1)  width of count port (derived, do not override)
// PORTS
//  clk        in   1      single clock, all state on posedge
//  rst        in   1      synchronous, active-high reset
//  load       in   1      parallel-load request (IDLE only)
//  load_data  in   WIDTH  value for parallel load
//  start      in   1      command request (IDLE only)
//  mode       in   2      00 ROR, 01 ROL, 10 SHR (ser_in->MSB), 11 SHL (ser_in->LSB)
//  count      in   CNT_W  number of steps for the command
//  ser_in     in   1      serial fill bit for SHR/SHL, sampled every step
//  q          out  WIDTH  register contents
//  ser_out    out  1      bit leaving next step: q[0] for ROR/SHR, q[WIDTH-1] for ROL/SHL
//  busy       out  1      high while steps remain
//  done       out  1      one-cycle pulse after last step
// BEHAVIOUR
//  - Reset (rst=1 at posedge): q=RESET_VAL, busy=0, done=0, state IDLE, latched mode=ROR.
//    Reset wins over everything, including mid-command: command aborted, no done pulse.
//  - FSM: IDLE -> RUN (start, count>0) | DONE (start, count==0); RUN -> DONE after last
//    step; DONE -> IDLE unconditionally. done=1 only in DONE; busy=1 only in RUN.
//  - Edge E0 in IDLE with start=1: latch mode and remaining=min(count,MAX_STEPS); q unchanged.
//    Steps on edges E1..EN, one per edge; done high in cycle after EN; busy high E0..EN.
//    count==0: no step, done high in cycle after E0, busy stays 0.
//  - Step: ROR q<={q[0],q[W-1:1]}; ROL q<={q[W-2:0],q[W-1]};
//    SHR q<={ser_in,q[W-1:1]}; SHL q<={q[W-2:0],ser_in}.
//  - load in IDLE: q<=load_data next edge. load and start in same IDLE cycle: load wins,
//    start dropped. load/start/mode/count during RUN or DONE ignored.
//  - ser_out combinational from q and latched mode (live mode not used).
//  - Back-to-back: start may be accepted in first IDLE cycle after DONE (2-cycle gap min).
// STRUCTURE
//  - Package shift_rotate_pkg: mode enum (MODE_ROR/ROL/SHR/SHL), state enum
//    (ST_IDLE/ST_RUN/ST_DONE), function step(q,mode,ser_in) returning next q.
//  - No sub-module; single always block for FSM+counter+register, assign for ser_out.
// TESTING
//  1 rst=1 one edge -> q=0x96, busy=0, done=0.
//  2 start mode=ROR count=1 -> q=0x4B after E1, done pulse one cycle, busy 1 cycle.
//  3 from 0x96 ROL count=3 -> 0x2D,0x5A,0xB4 on E1..E3; done after E3.
//  4 ROR count=8 -> q back to 0x96 after 8 steps; count=12 clamps to 8, same result.
//  5 load 0x00, SHR count=4 ser_in=1 -> q=0xF0; load 0xFF asserted during RUN ignored.
//  6 start count=0 -> q unchanged, done next cycle, busy never 1;
//    rst mid-RUN (step 2 of 5) -> q=0x96 next edge, no done pulse, IDLE.

Source files
------------

// File: rtl/shift_rotate_pkg.sv
// -----------------------------------------------------------------------------
// shift_rotate_pkg
//  Shared types and the single-step transfer function for shift_rotate_engine.
//  Contents:
//   mode_e   : step operation (ROR, ROL, SHR with ser_in->MSB, SHL with ser_in->LSB)
//   state_e  : control states (IDLE, RUN, DONE)
//   step()   : returns the register value after one step of the given mode.
//              It works on a STEP_MAX_W-bit container; the caller zero-extends
//              its register and passes the index of its real MSB.
// -----------------------------------------------------------------------------
package shift_rotate_pkg;

    // Widest register the step function can handle.
    localparam int STEP_MAX_W = 64;
    localparam int STEP_IDX_W = $clog2(STEP_MAX_W);

    typedef enum logic [1:0] {
        MODE_ROR = 2'b00,
        MODE_ROL = 2'b01,
        MODE_SHR = 2'b10,
        MODE_SHL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // One shift/rotate step. Bits of q above msb must be zero on entry and
    // are forced to zero on exit, so the container width never leaks into
    // the result.
    function automatic logic [STEP_MAX_W-1:0] step(
        input logic [STEP_MAX_W-1:0] q,
        input mode_e                 mode,
        input logic                  ser_in,
        input logic [STEP_IDX_W-1:0] msb
    );
        logic [STEP_MAX_W-1:0] res;
        logic [STEP_MAX_W-1:0] keep;
        keep = ~(({STEP_MAX_W{1'b1}} << msb) << 1);
        res  = '0;
        case (mode)
            MODE_ROR: begin
                res      = q >> 1;
                res[msb] = q[0];
            end
            MODE_ROL: begin
                res    = q << 1;
                res[0] = q[msb];
            end
            MODE_SHR: begin
                res      = q >> 1;
                res[msb] = ser_in;
            end
            MODE_SHL: begin
                res    = q << 1;
                res[0] = ser_in;
            end
            default: res = q;
        endcase
        return res & keep;
    endfunction

endpackage

// File: rtl/shift_rotate_engine.sv
// -----------------------------------------------------------------------------
// shift_rotate_engine
//  WIDTH-bit register with parallel load and a counted shift/rotate command.
//  A command is accepted in IDLE, performs one step per clock while busy,
//  then pulses done for one cycle before returning to IDLE.
//
//  Parameters
//   WIDTH      register width (2..64)
//   RESET_VAL  register value after reset
//   MAX_STEPS  largest step count honoured; larger requests are clamped
//   CNT_W      width of count (derived)
//
//  Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   load       parallel load request (honoured in IDLE only, beats start)
//   load_data  parallel load value
//   start      command request (honoured in IDLE only)
//   mode       00 ROR, 01 ROL, 10 SHR (ser_in->MSB), 11 SHL (ser_in->LSB)
//   count      number of steps for the command
//   ser_in     serial fill bit for SHR/SHL, sampled on every step
//   q          register contents
//   ser_out    bit that leaves on the next step, per latched mode
//   busy       high while steps remain (RUN)
//   done       one-cycle pulse after the last step (DONE)
// -----------------------------------------------------------------------------
module shift_rotate_engine
    import shift_rotate_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = 8'b10010110,
    parameter int               MAX_STEPS = WIDTH,
    parameter int               CNT_W     = $clog2(MAX_STEPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    generate
        if (WIDTH < 2 || WIDTH > STEP_MAX_W) begin : g_bad_width
            $error("shift_rotate_engine: WIDTH must be in 2..%0d", STEP_MAX_W);
        end
    endgenerate

    localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(MAX_STEPS);
    localparam logic [STEP_IDX_W-1:0] MSB_IDX = STEP_IDX_W'(WIDTH - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e           state_reg, state_next;
    mode_e            mode_reg,  mode_next;
    logic [WIDTH-1:0] q_reg,     q_next;
    logic [CNT_W-1:0] rem_reg,   rem_next;

    // -------------------------------------------------------------------------
    // One-step datapath: widen the register into the package container,
    // step it with the latched mode, and take our WIDTH bits back.
    // -------------------------------------------------------------------------
    logic [STEP_MAX_W-1:0] q_ext;
    logic [STEP_MAX_W-1:0] step_full;
    logic [WIDTH-1:0]      q_stepped;
    logic                  unused_step_bits;

    always_comb begin
        q_ext             = '0;
        q_ext[WIDTH-1:0]  = q_reg;
    end

    assign step_full        = step(q_ext, mode_reg, ser_in, MSB_IDX);
    assign q_stepped        = step_full[WIDTH-1:0];
    assign unused_step_bits = ^step_full;

    // Requested step count clamped to MAX_STEPS.
    logic [CNT_W-1:0] count_clamped;
    assign count_clamped = (count > MAX_CNT) ? MAX_CNT : count;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            mode_reg  <= MODE_ROR;
            q_reg     <= RESET_VAL;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            q_reg     <= q_next;
            rem_reg   <= rem_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        q_next     = q_reg;
        rem_next   = rem_reg;

        case (state_reg)
            ST_IDLE: begin
                if (load) begin
                    // Load has priority; a simultaneous start is dropped.
                    q_next = load_data;
                end else if (start) begin
                    mode_next = mode_e'(mode);
                    if (count == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        rem_next   = count_clamped;
                        state_next = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                q_next   = q_stepped;
                rem_next = rem_reg - 1'b1;
                if (rem_reg == CNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign q    = q_reg;
    assign busy = (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);

    // Right-moving modes drop the LSB, left-moving modes drop the MSB.
    assign ser_out = (mode_reg == MODE_ROR || mode_reg == MODE_SHR) ? q_reg[0]
                                                                    : q_reg[WIDTH-1];

endmodule
